// File: rtl/mio_bus_responder_pkg.sv
// Shared address map, timer register layout and helpers for mio_bus_responder.
package mio_bus_responder_pkg;

    localparam logic [31:0] IO_BASE   = 32'hF000_0000;
    localparam logic [31:0] LED_OFS   = 32'h0000_0000;
    localparam logic [31:0] SW_OFS    = 32'h0000_0004;
    localparam logic [31:0] TCNT_OFS  = 32'h0000_0008;
    localparam logic [31:0] TCMP_OFS  = 32'h0000_000C;
    localparam logic [31:0] TCTL_OFS  = 32'h0000_0010;

    localparam logic [31:0] LED_ADDR  = IO_BASE + LED_OFS;
    localparam logic [31:0] SW_ADDR   = IO_BASE + SW_OFS;
    localparam logic [31:0] TCNT_ADDR = IO_BASE + TCNT_OFS;
    localparam logic [31:0] TCMP_ADDR = IO_BASE + TCMP_OFS;
    localparam logic [31:0] TCTL_ADDR = IO_BASE + TCTL_OFS;

    localparam int TCTL_EN    = 0;
    localparam int TCTL_IE    = 1;
    localparam int TCTL_MATCH = 2;

    localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TCNT,
        SEL_TCMP,
        SEL_TCTL
    } sel_e;

    // Replace the bytes of old_word whose lane enable is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mio_timer.sv
// Compare-match timer (TCNT/TCMP/TCTL) with sticky MATCH flag and level interrupt.
// Only compiled when MIO_TIMER_EN is defined; without it this file is empty.
`ifdef MIO_TIMER_EN
module mio_timer
    import mio_bus_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic [3:0]  wea,
    input  logic        sel_tcnt,
    input  logic        sel_tcmp,
    input  logic        sel_tctl,
    input  logic [31:0] wdata,
    output logic [31:0] tcnt,
    output logic [31:0] tcmp,
    output logic [31:0] tctl,
    output logic        irq
);

    logic en;
    logic ie;
    logic match;
    logic hit;
    logic w1c;

    // Match is judged on the count before this edge's increment or load.
    assign hit = en && (tcnt == tcmp);
    assign w1c = wr && sel_tctl && wea[0] && wdata[TCTL_MATCH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            tcmp  <= TCMP_RESET;
            en    <= 1'b0;
            ie    <= 1'b0;
            match <= 1'b0;
        end else begin
            if (wr && sel_tcnt && (wea != 4'b0000)) tcnt <= byte_merge(tcnt, wdata, wea);
            else if (en)                            tcnt <= tcnt + 32'd1;

            if (wr && sel_tcmp) tcmp <= byte_merge(tcmp, wdata, wea);

            if (wr && sel_tctl && wea[0]) begin
                en <= wdata[TCTL_EN];
                ie <= wdata[TCTL_IE];
            end

            match <= hit || (match && !w1c);
        end
    end

    always_comb begin
        tctl             = '0;
        tctl[TCTL_EN]    = en;
        tctl[TCTL_IE]    = ie;
        tctl[TCTL_MATCH] = match;
    end

    assign irq = match && ie;

endmodule
`endif

// File: rtl/mio_bus_responder.sv
// CPU data-memory responder: word RAM, LED register, synchronized switches and,
// when MIO_TIMER_EN is defined, a compare-match timer driving INT.
module mio_bus_responder
    import mio_bus_responder_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int IO_W   = 16
) (
    input  logic            Clk_CPU,
    input  logic            rst,
    input  logic            CPU_MIO,
    input  logic            mem_w,
    input  logic [3:0]      wea,
    input  logic [31:0]     Addr_out,
    input  logic [31:0]     Data_out,
    output logic [31:0]     Data_in,
    output logic            MIO_ready,
    output logic            INT,
    input  logic [IO_W-1:0] sw_in,
    output logic [IO_W-1:0] led_out
);

    logic [31:0]       ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic [IO_W-1:0]   sw_meta;
    logic [IO_W-1:0]   sw_sync;
    logic              wr;
    logic              ram_we;
    logic              unused_addr_lsbs;
    sel_e              sel;

    assign wr               = CPU_MIO && mem_w;
    assign ram_idx          = Addr_out[RAM_AW+1:2];
    assign unused_addr_lsbs = ^Addr_out[1:0];

    // NOTE: every path assigns sel a default first, so no latch is inferred.
    always_comb begin
        sel = SEL_NONE;
        if (Addr_out[31:RAM_AW+2] == '0) begin
            sel = SEL_RAM;
        end else begin
            case ({Addr_out[31:2], 2'b00})
                LED_ADDR:  sel = SEL_LED;
                SW_ADDR:   sel = SEL_SW;
                TCNT_ADDR: sel = SEL_TCNT;
                TCMP_ADDR: sel = SEL_TCMP;
                TCTL_ADDR: sel = SEL_TCTL;
                default:   sel = SEL_NONE;
            endcase
        end
    end

    // A write arriving while reset is held is dropped rather than landing in RAM.
    assign ram_we = wr && (sel == SEL_RAM) && rst;

    // NOTE: the RAM has no reset so it maps onto block/distributed memory; its contents survive rst.
    always_ff @(posedge Clk_CPU) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wea[b]) ram[ram_idx][8*b +: 8] <= Data_out[8*b +: 8];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk_CPU or negedge rst) begin
        if (!rst) begin
            MIO_ready <= 1'b0;
            led_out   <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            MIO_ready <= 1'b1;
            sw_meta   <= sw_in;
            sw_sync   <= sw_meta;
            if (wr && (sel == SEL_LED)) begin
                for (int i = 0; i < IO_W; i++) begin
                    if (wea[i/8]) led_out[i] <= Data_out[i];
                end
            end
        end
    end

`ifdef MIO_TIMER_EN
    logic [31:0] tcnt;
    logic [31:0] tcmp;
    logic [31:0] tctl;

    mio_timer u_timer (
        .clk      (Clk_CPU),
        .rst_n    (rst),
        .wr       (wr),
        .wea      (wea),
        .sel_tcnt (sel == SEL_TCNT),
        .sel_tcmp (sel == SEL_TCMP),
        .sel_tctl (sel == SEL_TCTL),
        .wdata    (Data_out),
        .tcnt     (tcnt),
        .tcmp     (tcmp),
        .tctl     (tctl),
        .irq      (INT)
    );
`else
    assign INT = 1'b0;
`endif

    always_comb begin
        Data_in = '0;
        if (CPU_MIO) begin
            case (sel)
                SEL_RAM:  Data_in = ram[ram_idx];
                SEL_LED:  Data_in = 32'(led_out);
                SEL_SW:   Data_in = 32'(sw_sync);
`ifdef MIO_TIMER_EN
                SEL_TCNT: Data_in = tcnt;
                SEL_TCMP: Data_in = tcmp;
                SEL_TCTL: Data_in = tctl;
`endif
                default:  Data_in = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: a spec-level model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_mio_bus_responder;

    localparam int RAM_AW    = 10;
    localparam int IO_W      = 16;
    localparam int RAM_BYTES = 4 * (2**RAM_AW);
`ifdef MIO_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    localparam logic [31:0] A_LED  = 32'hF000_0000;
    localparam logic [31:0] A_SW   = 32'hF000_0004;
    localparam logic [31:0] A_TCNT = 32'hF000_0008;
    localparam logic [31:0] A_TCMP = 32'hF000_000C;
    localparam logic [31:0] A_TCTL = 32'hF000_0010;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            CPU_MIO = 1'b0;
    logic            mem_w = 1'b0;
    logic [3:0]      wea = 4'h0;
    logic [31:0]     Addr_out = '0;
    logic [31:0]     Data_out = '0;
    logic [31:0]     Data_in;
    logic            MIO_ready;
    logic            INT;
    logic [IO_W-1:0] sw_in = '0;
    logic [IO_W-1:0] led_out;

    int checks   = 0;
    int failures = 0;

    mio_bus_responder #(.RAM_AW(RAM_AW), .IO_W(IO_W)) dut (
        .Clk_CPU   (clk),
        .rst       (rst),
        .CPU_MIO   (CPU_MIO),
        .mem_w     (mem_w),
        .wea       (wea),
        .Addr_out  (Addr_out),
        .Data_out  (Data_out),
        .Data_in   (Data_in),
        .MIO_ready (MIO_ready),
        .INT       (INT),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0]     m_ram [int];
    logic [IO_W-1:0] m_led = '0;
    logic [IO_W-1:0] m_sw1 = '0;
    logic [IO_W-1:0] m_sw2 = '0;
    logic [31:0]     m_tcnt = '0;
    logic [31:0]     m_tcmp = 32'hFFFF_FFFF;
    bit              m_en = 1'b0, m_ie = 1'b0, m_match = 1'b0, m_ready = 1'b0;
    logic [31:0]     ma, mtmp;
    bit              mwr, mhit, mw1c;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready = 1'b0; m_led = '0; m_sw1 = '0; m_sw2 = '0;
            m_tcnt = '0; m_tcmp = 32'hFFFF_FFFF; m_en = 1'b0; m_ie = 1'b0; m_match = 1'b0;
        end else begin
            ma   = Addr_out & ~32'd3;
            mwr  = CPU_MIO && mem_w;
            mhit = TIMER && m_en && (m_tcnt == m_tcmp);
            mw1c = TIMER && mwr && ma == A_TCTL && wea[0] && Data_out[2];
            m_ready = 1'b1;
            m_sw2 = m_sw1;
            m_sw1 = sw_in;
            if (mwr && ma < RAM_BYTES && wea != 4'h0)
                m_ram[int'(ma >> 2)] = merge(m_ram.exists(int'(ma >> 2)) ? m_ram[int'(ma >> 2)] : '0,
                                             Data_out, wea);
            if (mwr && ma == A_LED) begin
                mtmp  = merge(32'(m_led), Data_out, wea);
                m_led = mtmp[IO_W-1:0];
            end
            if (TIMER && mwr && ma == A_TCNT && wea != 4'h0) m_tcnt = merge(m_tcnt, Data_out, wea);
            else if (m_en)                                    m_tcnt = m_tcnt + 1;
            if (TIMER && mwr && ma == A_TCMP) m_tcmp = merge(m_tcmp, Data_out, wea);
            if (TIMER && mwr && ma == A_TCTL && wea[0]) begin
                m_en = Data_out[0];
                m_ie = Data_out[1];
            end
            m_match = mhit || (m_match && !mw1c);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] ca, cexp;
    bit          cknown;

    always @(negedge clk) begin
        #2;
        cknown = 1'b1;
        cexp   = '0;
        ca     = Addr_out & ~32'd3;
        if (CPU_MIO) begin
            if (ca < RAM_BYTES) begin
                if (m_ram.exists(int'(ca >> 2))) cexp = m_ram[int'(ca >> 2)];
                else cknown = 1'b0;
            end
            else if (ca == A_LED)           cexp = 32'(m_led);
            else if (ca == A_SW)            cexp = 32'(m_sw2);
            else if (TIMER && ca == A_TCNT) cexp = m_tcnt;
            else if (TIMER && ca == A_TCMP) cexp = m_tcmp;
            else if (TIMER && ca == A_TCTL) cexp = {29'd0, m_match, m_ie, m_en};
        end
        if (cknown) check("model_rdata", Data_in, cexp);
        check("model_led", 32'(led_out), 32'(m_led));
        check("model_int", 32'(INT), 32'(m_match && m_ie));
        check("model_ready", 32'(MIO_ready), 32'(m_ready));
    end

    // ---------------- directed stimulus ----------------
    task automatic req(input bit mio, input bit w, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        CPU_MIO = mio; mem_w = w; wea = be; Addr_out = a; Data_out = d;
        #2;
    endtask

    initial begin
        #3;
        check("rst_ready", 32'(MIO_ready), 32'd0);
        check("rst_led", 32'(led_out), 32'd0);
        check("rst_int", 32'(INT), 32'd0);
        repeat (2) @(negedge clk);
        #2 check("ready_held_in_reset", 32'(MIO_ready), 32'd0);
        @(negedge clk) rst = 1'b1;

        // RAM byte lanes, pre-write read, no-op strobe, decode boundaries
        req(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        check("ready_after_reset", 32'(MIO_ready), 32'd1);
        req(1, 1, 4'h2, 32'h10, 32'h0000_5500);
        check("ram_prewrite_read", Data_in, 32'hDEAD_BEEF);
        req(1, 1, 4'h0, 32'h10, 32'h0000_0000);
        check("ram_byte_write", Data_in, 32'hDEAD_55EF);
        req(1, 0, 4'h0, 32'h10, 32'h0);
        check("ram_wea0_noop", Data_in, 32'hDEAD_55EF);
        req(0, 0, 4'h0, 32'h10, 32'h0);
        check("mio0_read_zero", Data_in, 32'h0);
        req(1, 1, 4'hF, 32'h0, 32'h1111_1111);
        req(1, 1, 4'hF, 32'hFFC, 32'hCAFE_F00D);
        req(1, 1, 4'hF, 32'h1000, 32'h2222_2222);
        req(1, 0, 4'h0, 32'h1000, 32'h0);
        check("unmapped_above_ram", Data_in, 32'h0);
        req(1, 0, 4'h0, 32'h0, 32'h0);
        check("ram_no_alias", Data_in, 32'h1111_1111);
        req(1, 0, 4'h0, 32'hFFE, 32'h0);
        check("ram_top_word", Data_in, 32'hCAFE_F00D);

        // LED, read-only SW, unmapped writes
        req(1, 1, 4'hF, A_LED, 32'h0000_1234);
        req(1, 0, 4'h0, A_LED, 32'h0);
        check("led_out", 32'(led_out), 32'h1234);
        check("led_read", Data_in, 32'h0000_1234);
        req(1, 1, 4'hF, A_SW, 32'hFFFF_FFFF);
        req(1, 1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF);
        req(1, 0, 4'h0, A_SW, 32'h0);
        check("sw_write_ignored", Data_in, 32'h0);
        req(1, 0, 4'h0, 32'h8000_0000, 32'h0);
        check("unmapped_write_ignored", Data_in, 32'h0);

        // Switch synchronizer latency
        req(1, 0, 4'h0, A_SW, 32'h0);
        sw_in = 16'hA5A5;
        check("sw_sync_edge0", Data_in, 32'h0);
        req(1, 0, 4'h0, A_SW, 32'h0);
        check("sw_sync_edge1", Data_in, 32'h0);
        req(1, 0, 4'h0, A_SW, 32'h0);
        check("sw_sync_edge2", Data_in, 32'h0000_A5A5);

`ifdef MIO_TIMER_EN
        req(1, 1, 4'hF, A_TCMP, 32'd5);
        req(1, 1, 4'hF, A_TCTL, 32'h3);
        for (int c = 0; c < 8; c++) begin
            req(1, 0, 4'h0, A_TCNT, 32'h0);
            check("tcnt_count", Data_in, 32'(c));
            check("int_after_match", 32'(INT), (c >= 6) ? 32'd1 : 32'd0);
        end
        req(1, 1, 4'hF, A_TCNT, 32'h20);
        req(1, 1, 4'hF, A_TCMP, 32'h23);
        req(1, 0, 4'h0, A_TCNT, 32'h0);
        check("tcnt_load", Data_in, 32'h21);
        req(1, 1, 4'hF, A_TCTL, 32'h7);
        check("tctl_pre_w1c", Data_in, 32'h7);
        req(1, 1, 4'hF, A_TCTL, 32'h7);
        check("tctl_w1c", Data_in, 32'h3);
        check("int_w1c", 32'(INT), 32'd0);
        req(1, 0, 4'h0, A_TCTL, 32'h0);
        check("tctl_set_wins", Data_in, 32'h7);
        check("int_set_wins", 32'(INT), 32'd1);
        req(1, 1, 4'h1, A_TCTL, 32'h1);
        req(1, 0, 4'h0, A_TCTL, 32'h0);
        check("tctl_ie_off", Data_in, 32'h5);
        check("int_masked", 32'(INT), 32'd0);
        req(1, 1, 4'hF, A_TCTL, 32'h7);
        req(1, 0, 4'h0, A_TCTL, 32'h0);
        check("tctl_cleared", Data_in, 32'h3);
        check("int_cleared", 32'(INT), 32'd0);
        req(1, 1, 4'hF, A_TCNT, 32'hFFFF_FFFF);
        req(1, 0, 4'h0, A_TCNT, 32'h0);
        check("tcnt_loaded_max", Data_in, 32'hFFFF_FFFF);
        req(1, 0, 4'h0, A_TCNT, 32'h0);
        check("tcnt_wrap", Data_in, 32'h0);
        req(1, 1, 4'hF, A_TCNT, 32'h1000);
        req(1, 0, 4'h0, A_TCNT, 32'h0);
        check("tcnt_load_priority", Data_in, 32'h1000);
        req(1, 1, 4'hF, A_TCMP, 32'h1003);
        req(1, 1, 4'hF, A_LED, 32'h0000_FFFF);
        req(0, 0, 4'h0, 32'h0, 32'h0);
        req(0, 0, 4'h0, 32'h0, 32'h0);
        check("int_before_reset", 32'(INT), 32'd1);
        check("led_before_reset", 32'(led_out), 32'hFFFF);
`else
        req(1, 1, 4'hF, A_TCNT, 32'h55);
        req(1, 1, 4'hF, A_TCTL, 32'h7);
        req(1, 0, 4'h0, A_TCNT, 32'h0);
        check("tcnt_unmapped", Data_in, 32'h0);
        req(1, 0, 4'h0, A_TCTL, 32'h0);
        check("tctl_unmapped", Data_in, 32'h0);
        req(1, 1, 4'hF, A_LED, 32'h0000_FFFF);
        req(0, 0, 4'h0, 32'h0, 32'h0);
        check("int_tied_low", 32'(INT), 32'd0);
        check("led_before_reset", 32'(led_out), 32'hFFFF);
`endif

        // Mid-operation reset with a RAM write pending
        req(1, 1, 4'hF, 32'h10, 32'h0);
        #1 rst = 1'b0;
        #1;
        check("rst_led_now", 32'(led_out), 32'd0);
        check("rst_int_now", 32'(INT), 32'd0);
        check("rst_ready_now", 32'(MIO_ready), 32'd0);
        req(1, 0, 4'h0, 32'h10, 32'h0);
        check("ram_survives_reset", Data_in, 32'hDEAD_55EF);
        @(negedge clk) rst = 1'b1;
        req(1, 0, 4'h0, A_TCTL, 32'h0);
        check("tctl_after_reset", Data_in, 32'h0);
        check("ready_after_release", 32'(MIO_ready), 32'd1);
        req(1, 0, 4'h0, 32'h10, 32'h0);
        check("ram_after_release", Data_in, 32'hDEAD_55EF);
        req(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
